// File: rtl/aes128_iter_core.sv
// AES-128 iterative encryption core: a loaded key is expanded once into a stored
// schedule, then handshaked plaintext blocks are encrypted at UNROLL rounds per clock.
module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         keys_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, EXPAND, READY, ROUND, OUT} state_t;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] LAST_R = 4'(10 - UNROLL);

  state_t       state, state_next;
  logic [127:0] key0;
  logic [127:0] expand_prev;
  logic [127:0] block;
  logic [127:0] round_keys [10];
  logic [3:0]   k;
  logic [3:0]   r;
  logic [127:0] gen_key;
  logic [127:0] round_result;
  logic         key_fire;
  logic         in_fire;
  logic         round_done;

  assign key_ready  = (state == IDLE) || (state == READY);
  assign in_ready   = (state == READY) && !key_valid;
  assign out_valid  = (state == OUT);
  assign busy       = (state == EXPAND) || (state == ROUND) || (state == OUT);
  assign key_fire   = key_valid && key_ready;
  assign in_fire    = in_valid && in_ready;
  assign round_done = (state == ROUND) && (r == LAST_R);

  GENERATE_KEY u_gen_key (
    .round_idx (k),
    .prev_key  (expand_prev),
    .next_key  (gen_key)
  );

  // Stage j consumes schedule slot r+j; only the stage landing on slot 9 skips MixColumns.
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [3:0]   slot;
    logic [127:0] rk;
    logic [127:0] stage_in;
    logic [127:0] stage_out;

    assign slot = r + 4'(j);
    assign rk   = (slot <= 4'd9) ? round_keys[slot] : '0;

    if (j == 0) begin : g_first
      assign stage_in = block;
    end else begin : g_chain
      assign stage_in = g_round[j-1].stage_out;
    end

    ROUND_ITERATION u_round (
      .state_in        (stage_in),
      .round_key       (rk),
      .last_round_flag (slot == 4'd9),
      .state_out       (stage_out)
    );
  end

  assign round_result = g_round[UNROLL-1].stage_out;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_fire) state_next = EXPAND;
      EXPAND:  if (k == 4'd9) state_next = READY;
      READY: begin
        if (key_fire)     state_next = EXPAND;
        else if (in_fire) state_next = ROUND;
      end
      ROUND:   if (round_done) state_next = OUT;
      OUT:     if (out_ready) state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  // expand_prev tracks the most recent key so the schedule builds without indexing slot k-1.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      key0        <= '0;
      expand_prev <= '0;
      block       <= '0;
      out_data    <= '0;
      k           <= '0;
      r           <= '0;
      keys_loaded <= 1'b0;
      for (int i = 0; i < 10; i++) round_keys[i] <= '0;
    end else begin
      if (key_fire) begin
        key0        <= key_in;
        expand_prev <= key_in;
        k           <= '0;
        keys_loaded <= 1'b0;
      end
      if (state == EXPAND) begin
        round_keys[k] <= gen_key;
        expand_prev   <= gen_key;
        k             <= k + 4'd1;
        if (k == 4'd9) keys_loaded <= 1'b1;
      end
      if (in_fire) begin
        block <= in_data ^ key0;
        r     <= '0;
      end
      if (state == ROUND) begin
        block <= round_result;
        r     <= r + 4'(UNROLL);
        if (round_done) out_data <= round_result;
      end
    end
  end

endmodule

// One step of the AES-128 key schedule: derives round key round_idx+1 from the previous one.
module GENERATE_KEY (
  input  logic [3:0]   round_idx,
  input  logic [127:0] prev_key,
  output logic [127:0] next_key
);

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    case (round_idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0  = prev_key[127:96];
  assign w1  = prev_key[95:64];
  assign w2  = prev_key[63:32];
  assign w3  = prev_key[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (.x(rot[8*b +: 8]), .y(sub[8*b +: 8]));
  end

  assign temp     = sub ^ {rcon, 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

// One AES round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
module ROUND_ITERATION (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round_flag,
  output logic [127:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.x(state_in[127-8*i -: 8]), .y(sb[i]));
  end

  // Byte i sits at row i%4, column i/4 of the column-major AES state.
  always_comb begin
    state_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        sr[rw + 4*c] = sb[rw + 4*((c + rw) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        mc[rw + 4*c] = xtime(sr[rw + 4*c]) ^ xtime(sr[(rw + 1) % 4 + 4*c])
                     ^ sr[(rw + 1) % 4 + 4*c] ^ sr[(rw + 2) % 4 + 4*c]
                     ^ sr[(rw + 3) % 4 + 4*c];
      end
    end
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = (last_round_flag ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
    end
  end

endmodule

// AES S-box computed as the GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  always_comb begin
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: four instances (UNROLL 1, 2, 5, 10) share stimulus
// and are compared against FIPS-197 vectors and a byte-level AES reference model.
module tb_aes128_iter_core;

  logic         clk = 1'b0;
  logic         resetn;
  logic         key_valid;
  logic [127:0] key_in;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic [3:0]   key_ready_v;
  logic [3:0]   keys_loaded_v;
  logic [3:0]   in_ready_v;
  logic [3:0]   out_valid_v;
  logic [3:0]   busy_v;
  logic [127:0] out_data_v [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int UN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_iter_core #(.UNROLL(UN)) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .key_valid   (key_valid),
      .key_ready   (key_ready_v[g]),
      .key_in      (key_in),
      .keys_loaded (keys_loaded_v[g]),
      .in_valid    (in_valid),
      .in_ready    (in_ready_v[g]),
      .in_data     (in_data),
      .out_valid   (out_valid_v[g]),
      .out_ready   (out_ready),
      .out_data    (out_data_v[g]),
      .busy        (busy_v[g])
    );
  end

  // Reference model: S-box table built by walking the multiplicative group with generator 3.
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int rw = 0; rw < 4; rw++) a[rw] = t[rw + 4*c];
          for (int rw = 0; rw < 4; rw++)
            t[rw + 4*c] = gmul(a[rw], 8'h02) ^ gmul(a[(rw+1)%4], 8'h03)
                        ^ a[(rw+2)%4] ^ a[(rw+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic int unroll_of(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 5;
      default: return 10;
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where keys_loaded is first seen.
  task automatic load_key(input logic [127:0] key, input bit offer_block);
    int lat;
    key_in    = key;
    key_valid = 1'b1;
    #1;
    check_output("key_ready_at_load", key_ready_v, 4'hf);
    if (offer_block) check_output("in_ready_blocked_by_key", in_ready_v, 4'h0);
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = rand128();
    check_output("busy_in_expand", busy_v, 4'hf);
    check_output("key_ready_in_expand", key_ready_v, 4'h0);
    check_output("keys_loaded_cleared", keys_loaded_v, 4'h0);
    check_output("in_ready_in_expand", in_ready_v, 4'h0);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      key_in = rand128();
      if (keys_loaded_v == 4'hf) lat = i;
    end
    check_output("keys_loaded_latency", lat, 10);
  endtask

  // Called at a falling edge in READY; all four instances take the block together.
  task automatic encrypt_all(input logic [127:0] pt, input logic [127:0] exp, input int hold);
    int lat [4];
    bit held_ok;
    in_data   = pt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check_output("in_ready_before_block", in_ready_v, 4'hf);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    check_output("busy_in_round", busy_v, 4'hf);
    check_output("in_ready_in_round", in_ready_v, 4'h0);
    lat     = '{0, 0, 0, 0};
    held_ok = 1'b1;
    for (int i = 1; i <= 10 + hold; i++) begin
      @(negedge clk);
      in_data = rand128();
      for (int d = 0; d < 4; d++) if (out_valid_v[d] && lat[d] == 0) lat[d] = i;
      if (i > 10 && (out_data_v[0] !== exp || in_ready_v[0] || key_ready_v[0] || !out_valid_v[0]))
        held_ok = 1'b0;
    end
    for (int d = 0; d < 4; d++) begin
      check_output($sformatf("latency_unroll%0d", unroll_of(d)), lat[d], 10 / unroll_of(d));
      check_output($sformatf("ciphertext_unroll%0d", unroll_of(d)), out_data_v[d], exp);
    end
    check_output("out_hold_stable", held_ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_after_accept", out_valid_v, 4'h0);
    check_output("ready_after_accept", key_ready_v, 4'hf);
    check_output("idle_busy_after_accept", busy_v, 4'h0);
    check_output("ciphertext_kept", out_data_v[0], exp);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  task automatic apply_stimulus(input vec_t v, input int hold);
    load_key(v.key, 1'b0);
    encrypt_all(v.pt, v.ct, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t         vecs [6];
    logic [127:0] k3, pt3, kb;
    logic [127:0] pts [3];
    logic [127:0] got_q [$];
    int           acc_q [$];
    int           idx;
    bit           acc;
    bit           post_ok;

    build_sbox();
    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32};
    for (int i = 2; i < 6; i++) begin
      vecs[i].key = rand128();
      vecs[i].pt  = rand128();
      vecs[i].ct  = model_encrypt(vecs[i].key, vecs[i].pt);
    end

    resetn    = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_out_valid", out_valid_v, 4'h0);
    check_output("reset_keys_loaded", keys_loaded_v, 4'h0);
    check_output("reset_busy", busy_v, 4'h0);
    check_output("reset_key_ready", key_ready_v, 4'hf);
    check_output("reset_in_ready", in_ready_v, 4'h0);
    for (int d = 0; d < 4; d++) check_output("reset_out_data", out_data_v[d], '0);
    resetn = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        load_key(vecs[i].key, 1'b0);
        check_output("round_key_slot9", g_dut[0].u_dut.round_keys[9],
                     128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        encrypt_all(vecs[i].pt, vecs[i].ct, 7);
      end else begin
        apply_stimulus(vecs[i], 1);
      end
    end

    k3       = rand128();
    pt3      = rand128();
    in_data  = pt3;
    in_valid = 1'b1;
    load_key(k3, 1'b1);
    encrypt_all(pt3, model_encrypt(k3, pt3), 1);

    in_data  = rand128();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;
    #1;
    check_output("midrun_reset_out_valid", out_valid_v, 4'h0);
    check_output("midrun_reset_keys_loaded", keys_loaded_v, 4'h0);
    check_output("midrun_reset_busy", busy_v, 4'h0);
    for (int d = 0; d < 4; d++) check_output("midrun_reset_out_data", out_data_v[d], '0);
    check_output("midrun_reset_slot9", g_dut[0].u_dut.round_keys[9], '0);
    @(negedge clk);
    resetn   = 1'b0;
    in_valid = 1'b1;
    post_ok  = 1'b1;
    repeat (5) begin
      #1;
      if (in_ready_v != 4'h0 || busy_v != 4'h0 || out_valid_v != 4'h0) post_ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_output("no_block_without_key", post_ok, 1'b1);

    kb = rand128();
    load_key(kb, 1'b0);
    for (int i = 0; i < 3; i++) pts[i] = rand128();
    idx       = 0;
    in_data   = pts[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && got_q.size() < 3; c++) begin
      #1;
      acc = in_valid && in_ready_v[0];
      if (acc) acc_q.push_back(c);
      if (out_valid_v[0]) got_q.push_back(out_data_v[0]);
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) in_data = pts[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("b2b_block_count", got_q.size(), 3);
    for (int i = 0; i < got_q.size() && i < 3; i++)
      check_output($sformatf("b2b_ciphertext%0d", i), got_q[i], model_encrypt(kb, pts[i]));
    for (int i = 1; i < acc_q.size(); i++)
      check_output($sformatf("b2b_interval%0d", i), acc_q[i] - acc_q[i-1], 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption engine with valid/ready handshakes on the key, plaintext and ciphertext channels.
- Expands a loaded key once into a stored 10-entry round-key schedule, then encrypts any number of blocks against it without re-expansion.
- Reuses the existing GENERATE_KEY (one instance) and ROUND_ITERATION (UNROLL instances) modules.
- Sits between the host data interface and downstream ciphertext consumers; supersedes the fixed, unhandshaked 10-stage top.

Parameters:
- UNROLL, 1, rounds applied per clock in the ROUND state. Legal values are 1, 2, 5, 10; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-high reset (asserted = 1, acts on posedge resetn).
- key_valid  in  1  key_in is valid.
- key_ready  out  1  core accepts a key this cycle.
- key_in  in  128  cipher key, FIPS-197 byte order (byte 0 in [127:120]).
- keys_loaded  out  1  a complete round-key schedule is stored.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core accepts a plaintext block this cycle.
- in_data  in  128  plaintext block.
- out_valid  out  1  out_data holds a ciphertext block.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  ciphertext block.
- busy  out  1  state is EXPAND, ROUND or OUT.

Behaviour:
- Reset: state=IDLE, keys_loaded=0, out_valid=0, out_data=0, busy=0, key0 and all round-key registers cleared. Reset asserted mid-operation aborts everything immediately; the key must be reloaded afterwards.
- States: IDLE, EXPAND, READY, ROUND, OUT.
- IDLE: key_ready=1, in_ready=0. A key handshake (key_valid & key_ready) goes to EXPAND.
- Key handshake effects: key_in is latched into key0; expansion counter k=0; keys_loaded=0.
- EXPAND: each cycle, GENERATE_KEY(round index k, previous key) is written to round-key slot k, then k is incremented. After 10 cycles (k=9 written), go to READY and set keys_loaded=1. key_valid is ignored in EXPAND.
- READY: key_ready=1. in_ready = !key_valid, so a key load wins over a plaintext on a simultaneous request.
  - Key handshake: re-expand (go to EXPAND).
  - Plaintext handshake: state register = in_data ^ key0, round counter r=0, go to ROUND.
- ROUND: each cycle applies UNROLL chained ROUND_ITERATION stages using round-key slots r..r+UNROLL-1. The stage that consumes slot 9 has LAST_ROUND_FLAG=1; all others have 0. r is advanced by UNROLL. When r reaches 10, the result is loaded into out_data and the state goes to OUT.
- Latency: out_valid rises exactly 10/UNROLL cycles after the plaintext handshake edge (10, 5, 2 or 1).
- OUT: out_valid=1 and out_data stays stable until out_ready is seen. On the out_ready edge, out_valid=0 and the state goes to READY.
  - in_ready=0 in OUT and ROUND; only one block is in flight.
  - out_data keeps the last ciphertext after out_valid falls.
- Throughput: at best one block every 10/UNROLL+2 cycles (handshake, rounds, OUT).
- key_ready=0 in EXPAND, ROUND and OUT; keys cannot be changed mid-block.
- busy=1 whenever state is EXPAND, ROUND or OUT.
- Inputs are sampled only on handshake edges; key_in and in_data changing at any other time have no effect.

Test Plan:
- Reset, then load key 000102030405060708090a0b0c0d0e0f; keys_loaded rises 10 cycles after the key handshake. Send pt 00112233445566778899aabbccddeeff with UNROLL=1 -> out_valid 10 cycles later, out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Load key 2b7e151628aed2a6abf7158809cf4f3c -> round-key slot 9 = d014f9a8c9ee2589e13f0cc8b6630ca6. pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Repeat with UNROLL=2, 5, 10 -> same ciphertext at latencies 5, 2, 1.
- Hold out_ready=0 for 7 cycles after out_valid -> out_data stable, in_ready=0 and key_ready=0 throughout. Release out_ready -> READY next cycle.
- Drive key_valid and in_valid together in READY -> key accepted, plaintext not accepted (in_ready=0), EXPAND entered. After expansion, the plaintext is accepted and encrypted under the new key.
- Assert resetn during ROUND (cycle 4) -> out_valid=0, out_data=0, keys_loaded=0, state IDLE. A plaintext offered afterwards is not accepted (in_ready=0) until a key is loaded.
- Three back-to-back blocks with out_ready tied to 1 and UNROLL=1 -> blocks accepted every 12 cycles, each ciphertext correct against an FIPS-197 reference model.
